glm_load_gen: RTL

Parametrised DMA load engine for the GLM datapath. Takes one load descriptor (DRAM address, line count, burst mode, destination mask), starts the DMA read channel, and issues credit-throttled line requests against an internal prefetch FIFO. Received lines are broadcast to a configurable number of on-chip region writers. Over the single-region-set loader it adds:
- parametric region count, data width and prefetch depth;
- per-load destination mask;
- burst selection that checks available credit;
- clean abort with in-flight drain.

---
 rtl/glm_load_pkg.sv | 25 ++
 rtl/glm_prefetch_fifo.sv | 58 +++++
 rtl/glm_load_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/glm_load_pkg.sv
// Shared types for the GLM load engine: FSM state encoding and the DMA
// burst-length encoding with its line-count decoder.
package glm_load_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DMA_START,
    S_REQUEST,
    S_DRAIN,
    S_DONE
  } t_loadstate;

  localparam logic [1:0] BURST1 = 2'b00;
  localparam logic [1:0] BURST2 = 2'b01;
  localparam logic [1:0] BURST4 = 2'b11;

  function automatic logic [2:0] burst_lines(input logic [1:0] rd_len);
    case (rd_len)
      BURST2:  return 3'd2;
      BURST4:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/glm_prefetch_fifo.sv
// Prefetch FIFO between the DMA read return and the region writers.
// Registered read port (rvalid one cycle after re), occupancy count, sync flush.
module glm_prefetch_fifo #(
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                we,
  input  logic [WIDTH-1:0]    wdata,
  input  logic                re,
  output logic [WIDTH-1:0]    rdata,
  output logic                rvalid,
  output logic [LOG2_DEPTH:0] count,
  output logic                empty
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr, rptr;
  logic                  full, do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign do_wr = we && !full && !flush;
  assign do_rd = re && !empty && !flush;

  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= do_rd;
      if (do_rd) begin
        rdata <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      if (do_wr) wptr <= wptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end

endmodule

// File: rtl/glm_load_gen.sv
// GLM DMA load engine: one descriptor per load, credit-throttled line
// requests into a prefetch FIFO, masked broadcast to the region writers.
module glm_load_gen
  import glm_load_pkg::*;
#(
  parameter int NUM_REGIONS         = 4,
  parameter int DATA_WIDTH          = 512,
  parameter int ADDR_WIDTH          = 42,
  parameter int LOG2_PREFETCH_DEPTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   op_start,
  input  logic                   op_abort,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [30:0]            cfg_length,
  input  logic                   cfg_multiline,
  input  logic [NUM_REGIONS-1:0] cfg_region_mask,
  output logic                   op_done,
  output logic                   op_aborted,
  output logic                   dma_start,
  output logic [ADDR_WIDTH-1:0]  dma_addr,
  output logic [31:0]            dma_length,
  input  logic                   dma_idle,
  input  logic                   dma_active,
  output logic                   rd_req,
  output logic [1:0]             rd_len,
  input  logic                   rd_valid,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_REGIONS-1:0] region_trigger,
  output logic [NUM_REGIONS-1:0] region_we,
  output logic [DATA_WIDTH-1:0]  region_wdata,
  input  logic [NUM_REGIONS-1:0] region_almostfull
);
  localparam int D = 1 << LOG2_PREFETCH_DEPTH;

  t_loadstate             state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [30:0]            len_q;
  logic                   multi_q;
  logic [NUM_REGIONS-1:0] mask_q, af_q;
  logic                   aborting, aborted_q;
  logic [31:0]            req_cnt, rcv_cnt, fwd_cnt;

  logic [DATA_WIDTH-1:0]          fifo_rdata;
  logic                           fifo_rvalid, fifo_empty, fifo_flush;
  logic [LOG2_PREFETCH_DEPTH:0]   fifo_count;

  logic [31:0]        len32, remain, b_lines;
  logic [1:0]         b_code;
  logic               has_burst, issue;
  logic signed [31:0] credit;
  logic               in_rx, pop_raw, pop, final_fwd, fill_done;
  logic               abort_hit, abort_done, rx_push, fwd_we_en, trig_fire;

  assign len32  = {1'b0, len_q};
  assign remain = len32 - req_cnt;

  always_comb begin
    b_code    = BURST1;
    has_burst = 1'b0;
    if (multi_q && remain >= 32'd4) begin
      b_code    = BURST4;
      has_burst = 1'b1;
    end else if (multi_q && remain >= 32'd2) begin
      b_code    = BURST2;
      has_burst = 1'b1;
    end else if (remain != 32'd0) begin
      has_burst = 1'b1;
    end
  end

  assign b_lines = {29'd0, burst_lines(b_code)};
  // Lines in flight plus lines buffered must never exceed the FIFO depth.
  assign credit  = D - $signed(32'(fifo_count)) - $signed(req_cnt - rcv_cnt);

  assign in_rx     = (state == S_REQUEST) || (state == S_DRAIN);
  assign fill_done = (fwd_cnt == len32);
  assign pop_raw   = !fifo_empty && !(|(af_q & mask_q)) && !aborting;
  assign final_fwd = pop_raw && (fwd_cnt + 32'd1 == len32);

  // An abort racing the last forward write loses: the load completes cleanly.
  assign abort_hit = op_abort &&
                     ((state == S_DMA_START) ||
                      (in_rx && !aborting && !final_fwd && !(state == S_DRAIN && fill_done)));
  assign abort_done = aborting &&
                      ((rcv_cnt == req_cnt) || (rd_valid && (rcv_cnt + 32'd1 == req_cnt)));

  assign pop        = pop_raw && !abort_hit;
  assign rx_push    = rd_valid && in_rx && !aborting && !abort_hit;
  assign fifo_flush = aborting || abort_hit;
  assign fwd_we_en  = fifo_rvalid && !aborting && !abort_hit;
  assign trig_fire  = (state == S_DMA_START) && !abort_hit && dma_idle;
  assign issue      = (state == S_REQUEST) && !abort_hit && dma_active && has_burst &&
                      (credit > 0) && (credit >= $signed(b_lines));

  assign dma_addr   = addr_q;
  assign dma_length = {multi_q, len_q};

  glm_prefetch_fifo #(
    .WIDTH      (DATA_WIDTH),
    .LOG2_DEPTH (LOG2_PREFETCH_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (fifo_flush),
    .we     (rx_push),
    .wdata  (rd_data),
    .re     (pop),
    .rdata  (fifo_rdata),
    .rvalid (fifo_rvalid),
    .count  (fifo_count),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= S_IDLE;
      addr_q         <= '0;
      len_q          <= '0;
      multi_q        <= 1'b0;
      mask_q         <= '0;
      af_q           <= '0;
      aborting       <= 1'b0;
      aborted_q      <= 1'b0;
      req_cnt        <= '0;
      rcv_cnt        <= '0;
      fwd_cnt        <= '0;
      op_done        <= 1'b0;
      op_aborted     <= 1'b0;
      dma_start      <= 1'b0;
      rd_req         <= 1'b0;
      rd_len         <= BURST1;
      region_trigger <= '0;
      region_we      <= '0;
      region_wdata   <= '0;
    end else begin
      op_done        <= 1'b0;
      op_aborted     <= 1'b0;
      dma_start      <= trig_fire;
      region_trigger <= trig_fire ? mask_q : '0;
      rd_req         <= issue;
      rd_len         <= issue ? b_code : BURST1;
      region_we      <= fwd_we_en ? mask_q : '0;
      af_q           <= region_almostfull;
      if (fwd_we_en)           region_wdata <= fifo_rdata;
      if (rd_valid && in_rx)   rcv_cnt <= rcv_cnt + 32'd1;
      if (issue)               req_cnt <= req_cnt + b_lines;
      if (pop)                 fwd_cnt <= fwd_cnt + 32'd1;

      case (state)
        S_IDLE:
          if (op_start) begin
            addr_q    <= cfg_addr;
            len_q     <= cfg_length;
            multi_q   <= cfg_multiline;
            mask_q    <= cfg_region_mask;
            aborting  <= 1'b0;
            aborted_q <= 1'b0;
            req_cnt   <= '0;
            rcv_cnt   <= '0;
            fwd_cnt   <= '0;
            state     <= (cfg_length == '0) ? S_DONE : S_DMA_START;
          end
        S_DMA_START:
          if (abort_hit) begin
            aborted_q <= 1'b1;
            state     <= S_DONE;
          end else if (dma_idle) begin
            state <= S_REQUEST;
          end
        S_REQUEST:
          if (abort_hit) begin
            aborting  <= 1'b1;
            aborted_q <= 1'b1;
            state     <= S_DRAIN;
          end else if (req_cnt == len32) begin
            state <= S_DRAIN;
          end
        S_DRAIN:
          if (aborting) begin
            if (abort_done) state <= S_DONE;
          end else if (abort_hit) begin
            aborting  <= 1'b1;
            aborted_q <= 1'b1;
          end else if (fill_done) begin
            state <= S_DONE;
          end
        S_DONE: begin
          op_done    <= 1'b1;
          op_aborted <= aborted_q;
          aborting   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end

endmodule
